// File: rtl/data_mem_arbiter.sv
// Two-master data memory arbiter: one access in flight, issue every 2 cycles.
// Round-robin on ties by default; DMEM_ARB_FIXED_PRIO_EN selects fixed priority (m0 wins).
module data_mem_arbiter #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_cant_byte,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_cant_byte,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              mem_cant_byte,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            r_state;
    logic              r_win;
    logic              r_we;
    logic              r_cb;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;

    logic              w_any;
    logic              w_pick;
    logic              w_we;
    logic              w_cb;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_any = m0_req | m1_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_pick = ~m0_req;
`else
    // r_ptr holds the most recently granted master; a tie goes to the other one.
    logic r_ptr;
    assign w_pick = (m0_req & m1_req) ? ~r_ptr : m1_req;
`endif

    assign w_we    = w_pick ? m1_we        : m0_we;
    assign w_cb    = w_pick ? m1_cant_byte : m0_cant_byte;
    assign w_addr  = w_pick ? m1_addr      : m0_addr;
    assign w_wdata = w_pick ? m1_wdata     : m0_wdata;

    always_ff @(posedge clk) begin
        r_gnt0  <= 1'b0;
        r_gnt1  <= 1'b0;
        r_done0 <= 1'b0;
        r_done1 <= 1'b0;
        if (reset) begin
            r_state  <= StIdle;
            r_win    <= 1'b0;
            r_we     <= 1'b0;
            r_cb     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            r_ptr    <= 1'b1;
`endif
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (w_any) begin
                        r_state <= StAccess;
                        r_win   <= w_pick;
                        r_we    <= w_we;
                        r_cb    <= w_cb;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_gnt0  <= ~w_pick;
                        r_gnt1  <= w_pick;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StAccess: begin
                    r_state <= StDone;
                    r_done0 <= ~r_win;
                    r_done1 <= r_win;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    r_ptr   <= r_win;
`endif
                    if (!r_we) begin
                        if (r_win) r_rdata1 <= mem_rd;
                        else       r_rdata0 <= mem_rd;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign m0_gnt        = r_gnt0;
    assign m1_gnt        = r_gnt1;
    assign m0_done       = r_done0;
    assign m1_done       = r_done1;
    assign m0_rdata      = r_rdata0;
    assign m1_rdata      = r_rdata1;
    assign mem_a         = r_addr;
    assign mem_wd        = r_wdata;
    assign mem_cant_byte = r_cb;
    // Gated by reset directly so an aborted access never commits.
    assign mem_we        = (r_state == StAccess) & r_we & ~reset;
    assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus randomized
// rounds checked against a transaction-level model with a shadow byte memory.
module tb_data_mem_arbiter;
    localparam int AW = 19;
    localparam int DW = 19;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m0_cant_byte, m0_gnt, m0_done;
    logic          m1_req, m1_we, m1_cant_byte, m1_gnt, m1_done;
    logic [AW-1:0] m0_addr, m1_addr, mem_a;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wd, mem_rd;
    logic          mem_we, mem_cant_byte, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] dmem   [256] = '{default: 8'h00};
    logic [7:0] shadow [256] = '{default: 8'h00};
    logic [7:0] w_lo, w_hi;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_cant_byte(m0_cant_byte), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_cant_byte(m1_cant_byte), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_cant_byte(mem_cant_byte),
        .mem_rd(mem_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Little-endian byte memory behind the arbiter.
    assign w_lo   = mem_a[7:0];
    assign w_hi   = w_lo + 8'd1;
    assign mem_rd = mem_cant_byte ? {3'b000, dmem[w_hi], dmem[w_lo]} : {11'd0, dmem[w_lo]};
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            dmem[w_lo] <= mem_wd[7:0];
            if (mem_cant_byte) dmem[w_hi] <= mem_wd[15:8];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input bit req, input bit we, input bit cb,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_cant_byte = cb; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = req; m1_we = we; m1_cant_byte = cb; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_m(0, 1'b1, 1'b1, 1'b1, 19'h12345, 19'h0ABCD);
        set_m(1, 1'b1, 1'b1, 1'b0, 19'h00321, 19'h00055);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({m0_gnt, m1_gnt, m0_done, m1_done, busy, mem_we} !== 6'b0) begin
                errors++;
                $display("FAIL rst_ctrl: got gnt/done/busy/we=%b required 000000",
                         {m0_gnt, m1_gnt, m0_done, m1_done, busy, mem_we});
            end
        end
        checks++;
        if (m0_rdata !== '0 || m1_rdata !== '0) begin
            errors++;
            $display("FAIL rst_rdata: got %h/%h required 0/0", m0_rdata, m1_rdata);
        end
        checks++;
        if (mem_a !== '0 || mem_wd !== '0 || mem_cant_byte !== 1'b0) begin
            errors++;
            $display("FAIL rst_fields: got a=%h wd=%h cb=%b required zeros",
                     mem_a, mem_wd, mem_cant_byte);
        end
        set_m(0, 1'b1, 1'b0, 1'b1, 19'h00000, 19'h0);
        m1_req = 1'b0;
        reset  = 1'b0;
        tick();
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_resume_gnt: got %b required 1", m0_gnt);
        end
        m0_req = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_resume_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_hw_write_read;
        int we_cnt = 0;
        set_m(0, 1'b1, 1'b1, 1'b1, 19'h00010, 19'h0BEEF);
        tick(); we_cnt += int'(mem_we);
        checks++;
        if (m0_gnt !== 1'b1 || mem_a !== 19'h00010 || mem_wd !== 19'h0BEEF) begin
            errors++;
            $display("FAIL hw_wr_access: got gnt=%b a=%h wd=%h required 1/00010/0beef",
                     m0_gnt, mem_a, mem_wd);
        end
        m0_req = 1'b0;
        tick(); we_cnt += int'(mem_we);
        checks++;
        if (m0_done !== 1'b1) begin
            errors++;
            $display("FAIL hw_wr_done: got %b required 1", m0_done);
        end
        set_m(0, 1'b1, 1'b0, 1'b1, 19'h00010, 19'h0);
        tick(); we_cnt += int'(mem_we);
        m0_req = 1'b0;
        tick(); we_cnt += int'(mem_we);
        checks++;
        if (m0_done !== 1'b1 || m0_rdata !== 19'h0BEEF) begin
            errors++;
            $display("FAIL hw_rd_data: got done=%b rdata=%h required 1/0beef", m0_done, m0_rdata);
        end
        tick(); we_cnt += int'(mem_we);
        checks++;
        if (we_cnt != 1) begin
            errors++;
            $display("FAIL hw_we_cycles: got %0d required 1", we_cnt);
        end
    endtask

    task automatic test_byte_write;
        set_m(1, 1'b1, 1'b1, 1'b0, 19'h00021, 19'h000AA);
        tick();
        checks++;
        if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_cant_byte !== 1'b0) begin
            errors++;
            $display("FAIL byte_wr_access: got gnt=%b we=%b cb=%b required 1/1/0",
                     m1_gnt, mem_we, mem_cant_byte);
        end
        m1_req = 1'b0;
        tick();
        checks++;
        if (m1_done !== 1'b1 || m1_rdata !== 19'h0) begin
            errors++;
            $display("FAIL byte_wr_done: got done=%b rdata=%h required 1/00000", m1_done, m1_rdata);
        end
        set_m(1, 1'b1, 1'b0, 1'b1, 19'h00020, 19'h0);
        tick();
        m1_req = 1'b0;
        tick();
        checks++;
        if (m1_done !== 1'b1 || m1_rdata !== 19'h0AA00) begin
            errors++;
            $display("FAIL byte_rd_data: got done=%b rdata=%h required 1/0aa00", m1_done, m1_rdata);
        end
        tick();
    endtask

    task automatic test_tie_order;
        logic [1:0] exp_g;
        pulse_reset();
        set_m(0, 1'b1, 1'b0, 1'b1, 19'h00010, 19'h0);
        set_m(1, 1'b1, 1'b0, 1'b1, 19'h00020, 19'h0);
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t % 2 == 1) exp_g = (!FIXED && ((t / 2) % 2 == 1)) ? 2'b10 : 2'b01;
            else            exp_g = 2'b00;
            checks++;
            if ({m1_gnt, m0_gnt} !== exp_g) begin
                errors++;
                $display("FAIL tie_order_t%0d: got {gnt1,gnt0}=%b required %b",
                         t, {m1_gnt, m0_gnt}, exp_g);
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_abort;
        int seen_done = 0;
        pulse_reset();
        set_m(0, 1'b1, 1'b0, 1'b1, 19'h00010, 19'h0);
        tick();
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL abort_rd_gnt: got %b required 1", m0_gnt);
        end
        reset  = 1'b1;
        m0_req = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || m0_done !== 1'b0 || m0_rdata !== '0) begin
            errors++;
            $display("FAIL abort_rd_state: got busy=%b done=%b rdata=%h required 0/0/00000",
                     busy, m0_done, m0_rdata);
        end
        reset = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b1, 19'h00040, 19'h01234);
        tick();
        checks++;
        if (m0_gnt !== 1'b1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL abort_wr_access: got gnt=%b we=%b required 1/1", m0_gnt, mem_we);
        end
        reset  = 1'b1;
        m0_req = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_wr_we: got %b required 0", mem_we);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen_done += int'(m0_done);
            tick();
        end
        checks++;
        if (seen_done != 0 || dmem[8'h40] !== 8'h00 || dmem[8'h41] !== 8'h00) begin
            errors++;
            $display("FAIL abort_no_commit: got dones=%0d mem=%h%h required 0/0000",
                     seen_done, dmem[8'h41], dmem[8'h40]);
        end
    endtask

    task automatic test_single_held;
        pulse_reset();
        set_m(1, 1'b1, 1'b0, 1'b1, 19'h00021, 19'h0);
        for (int t = 1; t <= 6; t++) begin
            tick();
            checks++;
            if ({m1_gnt, m1_done, m0_gnt, m0_done} !== {t % 2 == 1, t % 2 == 0, 2'b00}) begin
                errors++;
                $display("FAIL single_t%0d: got gnt1/done1/gnt0/done0=%b required %b",
                         t, {m1_gnt, m1_done, m0_gnt, m0_done}, {t % 2 == 1, t % 2 == 0, 2'b00});
            end
        end
        m1_req = 1'b0;
        tick();
    endtask

    task automatic test_random;
        bit            rq [2];
        bit            rwe [2];
        bit            rcb [2];
        logic [AW-1:0] ra [2];
        logic [DW-1:0] rd [2];
        logic [DW-1:0] exp_rd [2];
        int            ord [2];
        int            n, gi, di, g, d, last, lo;
        logic [1:0]    sel;
        pulse_reset();
        last   = 1;
        exp_rd = '{19'h0, 19'h0};
        for (int r = 0; r < 40; r++) begin
            sel = 2'($urandom_range(1, 3));
            for (int m = 0; m < 2; m++) begin
                rq[m]  = sel[m];
                rwe[m] = 1'($urandom_range(0, 1));
                rcb[m] = 1'($urandom_range(0, 1));
                ra[m]  = {11'($urandom), 8'($urandom_range(128, 254))};
                rd[m]  = 19'($urandom);
            end
            if (rq[0] && rq[1]) begin
                ord[0] = (FIXED || last == 1) ? 0 : 1;
                ord[1] = 1 - ord[0];
                n = 2;
            end else begin
                ord[0] = rq[1] ? 1 : 0;
                n = 1;
            end
            set_m(0, rq[0], rwe[0], rcb[0], ra[0], rd[0]);
            set_m(1, rq[1], rwe[1], rcb[1], ra[1], rd[1]);
            gi = 0;
            di = 0;
            for (int t = 0; t < 8 && di < n; t++) begin
                tick();
                checks++;
                if ((m0_gnt && m1_gnt) || (m0_done && m1_done)) begin
                    errors++;
                    $display("FAIL rnd_excl r%0d: got gnt=%b%b done=%b%b required one-hot",
                             r, m1_gnt, m0_gnt, m1_done, m0_done);
                end
                if (m0_gnt || m1_gnt) begin
                    g = m1_gnt ? 1 : 0;
                    checks++;
                    if (gi >= n || g != ord[gi]) begin
                        errors++;
                        $display("FAIL rnd_gnt r%0d: got master %0d required %0d",
                                 r, g, (gi < n) ? ord[gi] : -1);
                    end else if (mem_a !== ra[g] || mem_we !== rwe[g] ||
                                 mem_cant_byte !== rcb[g] || (rwe[g] && mem_wd !== rd[g])) begin
                        errors++;
                        $display("FAIL rnd_bus r%0d: got a=%h we=%b cb=%b wd=%h required %h/%b/%b/%h",
                                 r, mem_a, mem_we, mem_cant_byte, mem_wd,
                                 ra[g], rwe[g], rcb[g], rd[g]);
                    end
                    lo = int'(ra[g][7:0]);
                    if (rwe[g]) begin
                        shadow[lo] = rd[g][7:0];
                        if (rcb[g]) shadow[lo + 1] = rd[g][15:8];
                    end else begin
                        exp_rd[g] = rcb[g] ? {3'b000, shadow[lo + 1], shadow[lo]}
                                           : {11'd0, shadow[lo]};
                    end
                    if (g == 0) m0_req = 1'b0;
                    else        m1_req = 1'b0;
                    last = g;
                    gi++;
                end
                if (m0_done || m1_done) begin
                    d = m1_done ? 1 : 0;
                    checks++;
                    if ((d == 1 ? m1_rdata : m0_rdata) !== exp_rd[d]) begin
                        errors++;
                        $display("FAIL rnd_rdata r%0d m%0d: got %h required %h",
                                 r, d, (d == 1 ? m1_rdata : m0_rdata), exp_rd[d]);
                    end
                    di++;
                end
            end
            checks++;
            if (gi != n || di != n) begin
                errors++;
                $display("FAIL rnd_count r%0d: got gnts=%0d dones=%0d required %0d",
                         r, gi, di, n);
            end
            m0_req = 1'b0;
            m1_req = 1'b0;
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rnd_idle r%0d: got busy=%b required 0", r, busy);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
        test_reset();
        test_hw_write_read();
        test_byte_write();
        test_tie_order();
        test_reset_abort();
        test_single_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
